// File: rtl/hwjsoc_oci_dct_pkg.sv
// Shared constants, FSM states and packet payload for the OCI DCT trace packer.
package hwjsoc_oci_dct_pkg;

    localparam int unsigned DCT_CODE_W = 2;
    localparam int unsigned DCT_DEPTH  = 15;
    localparam int unsigned DCT_BUF_W  = 30;
    localparam int unsigned DCT_CNT_W  = 4;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        ENDING = 2'd1,
        ENDED  = 2'd2
    } dct_state_e;

    // One packet: payload (newest code in the low bits) plus valid-code count.
    typedef struct packed {
        logic [DCT_BUF_W-1:0] data;
        logic [DCT_CNT_W-1:0] cnt;
    } dct_pkt_t;

endpackage

// File: rtl/hwjsoc_oci_dct_outreg.sv
// One-packet output holding register with valid/ready handshake.
//   clk, reset     : clock, synchronous active-high reset
//   load_i, pkt_i  : load a new packet (may coincide with consumer acceptance)
//   out_ready_i    : consumer accepts the packet
//   buf_o, cnt_o   : held packet payload / count
//   valid_o        : packet valid
//   slot_free_c_o  : register is empty or being emptied this cycle
module hwjsoc_oci_dct_outreg
    import hwjsoc_oci_dct_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load_i,
    input  dct_pkt_t             pkt_i,
    input  logic                 out_ready_i,
    output logic [DCT_BUF_W-1:0] buf_o,
    output logic [DCT_CNT_W-1:0] cnt_o,
    output logic                 valid_o,
    output logic                 slot_free_c_o
);

    dct_pkt_t pkt_q, pkt_d;
    logic     valid_q, valid_d;

    assign slot_free_c_o = !valid_q || out_ready_i;

    // Payload only changes on load, so it stays stable under backpressure.
    always_comb begin
        pkt_d   = pkt_q;
        valid_d = valid_q;
        if (load_i) begin
            pkt_d   = pkt_i;
            valid_d = 1'b1;
        end else if (out_ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pkt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            pkt_q   <= pkt_d;
            valid_q <= valid_d;
        end
    end

    assign buf_o   = pkt_q.data;
    assign cnt_o   = pkt_q.cnt;
    assign valid_o = valid_q;

endmodule

// File: rtl/hwjsoc_cpu_oci_dct_packer.sv
// OCI direct-conditional-branch trace packer: accumulates 2-bit trace codes
// into 30-bit packets and hands them to the consumer over valid/ready; also
// runs the end-of-test drain handshake.
//   clk, reset                       : clock, synchronous active-high reset
//   trc_on                           : store accepted codes when high
//   dct_in_valid/code/ready          : code input handshake
//   dct_flush                        : close the partial packet
//   test_ending / test_has_ended     : end-of-test request / sticky done
//   dct_buffer/count/out_valid/ready : packet output handshake
module hwjsoc_cpu_oci_dct_packer
    import hwjsoc_oci_dct_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  trc_on,
    input  logic                  dct_in_valid,
    input  logic [DCT_CODE_W-1:0] dct_in_code,
    output logic                  dct_in_ready,
    input  logic                  dct_flush,
    input  logic                  test_ending,
    output logic [DCT_BUF_W-1:0]  dct_buffer,
    output logic [DCT_CNT_W-1:0]  dct_count,
    output logic                  dct_out_valid,
    input  logic                  dct_out_ready,
    output logic                  test_has_ended
);

    localparam logic [DCT_CNT_W-1:0] DEPTH_CNT = DCT_CNT_W'(DCT_DEPTH);

    dct_state_e           state_q, state_d;
    logic [DCT_BUF_W-1:0] acc_buf_q, acc_buf_d;
    logic [DCT_CNT_W-1:0] acc_cnt_q, acc_cnt_d;
    logic                 flush_pend_q, flush_pend_d;
    logic                 ended_q, ended_d;

    logic                 slot_free_c;
    logic                 acc_full_c;
    logic                 xfer_c;
    logic                 in_ready_c;
    logic                 store_c;
    logic [DCT_BUF_W-1:0] base_buf_c;
    logic [DCT_CNT_W-1:0] base_cnt_c;
    dct_pkt_t             acc_pkt_c;

    assign acc_full_c = (acc_cnt_q == DEPTH_CNT);
    assign xfer_c     = slot_free_c && (acc_full_c || (flush_pend_q && (acc_cnt_q != '0)));
    // A full accumulator can still take a code when it drains this cycle.
    assign in_ready_c = !reset && (state_q == RUN) && !flush_pend_q
                        && !(acc_full_c && !slot_free_c);
    assign store_c    = dct_in_valid && in_ready_c && trc_on;
    assign dct_in_ready = in_ready_c;

    assign acc_pkt_c = '{data: acc_buf_q, cnt: acc_cnt_q};

    // Accumulator: clears on transfer; a same-cycle code becomes entry 1.
    always_comb begin
        base_buf_c = xfer_c ? '0 : acc_buf_q;
        base_cnt_c = xfer_c ? '0 : acc_cnt_q;
        acc_buf_d  = base_buf_c;
        acc_cnt_d  = base_cnt_c;
        if (store_c) begin
            acc_buf_d = {base_buf_c[DCT_BUF_W-DCT_CODE_W-1:0], dct_in_code};
            acc_cnt_d = base_cnt_c + DCT_CNT_W'(1);
        end
    end

    // FSM next state, flush request and end-of-test flag.
    always_comb begin
        state_d      = state_q;
        flush_pend_d = flush_pend_q;
        ended_d      = ended_q;
        if (flush_pend_q && (xfer_c || (acc_cnt_q == '0))) begin
            flush_pend_d = 1'b0;
        end
        case (state_q)
            RUN: begin
                if (test_ending || dct_flush) begin
                    flush_pend_d = 1'b1;
                end
                if (test_ending) begin
                    state_d = ENDING;
                end
            end
            ENDING: begin
                if ((acc_cnt_q == '0) && !dct_out_valid) begin
                    state_d = ENDED;
                    ended_d = 1'b1;
                end
            end
            ENDED: begin
                ended_d = 1'b1;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= RUN;
            acc_buf_q    <= '0;
            acc_cnt_q    <= '0;
            flush_pend_q <= 1'b0;
            ended_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_buf_q    <= acc_buf_d;
            acc_cnt_q    <= acc_cnt_d;
            flush_pend_q <= flush_pend_d;
            ended_q      <= ended_d;
        end
    end

    assign test_has_ended = ended_q;

    hwjsoc_oci_dct_outreg u_outreg (
        .clk           (clk),
        .reset         (reset),
        .load_i        (xfer_c),
        .pkt_i         (acc_pkt_c),
        .out_ready_i   (dct_out_ready),
        .buf_o         (dct_buffer),
        .cnt_o         (dct_count),
        .valid_o       (dct_out_valid),
        .slot_free_c_o (slot_free_c)
    );

endmodule

// File: tb/tb_hwjsoc_cpu_oci_dct_packer.sv
// Scoreboard bench for the OCI DCT packer: tasks push expected packets,
// a negedge monitor pops and compares them at each output handshake.
module tb_hwjsoc_cpu_oci_dct_packer;

    logic        clk = 1'b0;
    logic        reset;
    logic        trc_on;
    logic        dct_in_valid;
    logic [1:0]  dct_in_code;
    logic        dct_in_ready;
    logic        dct_flush;
    logic        test_ending;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        dct_out_valid;
    logic        dct_out_ready;
    logic        test_has_ended;

    int n_vec = 0;
    int n_err = 0;
    int pkt_seen = 0;
    logic [33:0] exp_q[$];

    hwjsoc_cpu_oci_dct_packer dut (
        .clk            (clk),
        .reset          (reset),
        .trc_on         (trc_on),
        .dct_in_valid   (dct_in_valid),
        .dct_in_code    (dct_in_code),
        .dct_in_ready   (dct_in_ready),
        .dct_flush      (dct_flush),
        .test_ending    (test_ending),
        .dct_buffer     (dct_buffer),
        .dct_count      (dct_count),
        .dct_out_valid  (dct_out_valid),
        .dct_out_ready  (dct_out_ready),
        .test_has_ended (test_has_ended)
    );

    always #5 clk = ~clk;

    // Handshake monitor: valid && ready at negedge completes at the next posedge.
    always @(negedge clk) begin : mon
        logic [33:0] e;
        if (!reset && dct_out_valid && dct_out_ready) begin
            pkt_seen++;
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_packet: got buffer=%h count=%0d, required no packet",
                         dct_buffer, dct_count);
            end else begin
                e = exp_q.pop_front();
                if ({dct_buffer, dct_count} !== e) begin
                    n_err++;
                    $display("FAIL packet: got buffer=%h count=%0d, required buffer=%h count=%0d",
                             dct_buffer, dct_count, e[33:4], e[3:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_code(input logic [1:0] c);
        int  w;
        bit  done;
        w = 0;
        done = 1'b0;
        dct_in_valid = 1'b1;
        dct_in_code  = c;
        while (!done) begin
            @(negedge clk);
            if (dct_in_ready) begin
                done = 1'b1;
            end else begin
                w++;
                if (w > 50) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL send_timeout: dct_in_ready stayed %b, required 1 within 50 cycles",
                             dct_in_ready);
                    done = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        dct_in_valid = 1'b0;
    endtask

    task automatic flush_pulse();
        dct_flush = 1'b1;
        tick();
        dct_flush = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        n_vec++; if (dct_out_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b required 0", dct_out_valid); end
        n_vec++; if (dct_buffer !== 30'h0) begin n_err++; $display("FAIL rst_buffer: got %h required 0", dct_buffer); end
        n_vec++; if (dct_count !== 4'h0) begin n_err++; $display("FAIL rst_count: got %0d required 0", dct_count); end
        n_vec++; if (dct_in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready: got %b required 0", dct_in_ready); end
        n_vec++; if (test_has_ended !== 1'b0) begin n_err++; $display("FAIL rst_ended: got %b required 0", test_has_ended); end
        reset = 1'b0;
        tick();
        n_vec++; if (dct_in_ready !== 1'b1) begin n_err++; $display("FAIL run_in_ready: got %b required 1", dct_in_ready); end
    endtask

    task automatic test_full_packet();
        int p0;
        int vcyc;
        p0 = pkt_seen;
        vcyc = 0;
        exp_q.push_back({30'h1999_9999, 4'd15});
        for (int i = 0; i < 15; i++) send_code((i % 2 == 0) ? 2'b01 : 2'b10);
        n_vec++; if (dct_out_valid !== 1'b0) begin n_err++; $display("FAIL full_latency_early: got valid=%b required 0", dct_out_valid); end
        tick();
        n_vec++; if (dct_out_valid !== 1'b1) begin n_err++; $display("FAIL full_latency: got valid=%b required 1", dct_out_valid); end
        if (dct_out_valid) vcyc++;
        repeat (8) begin
            tick();
            if (dct_out_valid) vcyc++;
        end
        n_vec++; if (vcyc !== 1) begin n_err++; $display("FAIL full_valid_cycles: got %0d required 1", vcyc); end
        n_vec++; if (pkt_seen - p0 !== 1 || exp_q.size() !== 0) begin n_err++; $display("FAIL full_pkts: got %0d left=%0d required 1 left=0", pkt_seen - p0, exp_q.size()); end
    endtask

    task automatic test_partial_flush();
        int p0;
        p0 = pkt_seen;
        exp_q.push_back({30'h39, 4'd3});
        send_code(2'b11);
        send_code(2'b10);
        send_code(2'b01);
        flush_pulse();
        repeat (5) tick();
        n_vec++; if (pkt_seen - p0 !== 1 || exp_q.size() !== 0) begin n_err++; $display("FAIL partial_pkts: got %0d left=%0d required 1 left=0", pkt_seen - p0, exp_q.size()); end
        p0 = pkt_seen;
        flush_pulse();
        repeat (5) tick();
        n_vec++; if (pkt_seen - p0 !== 0) begin n_err++; $display("FAIL empty_flush: got %0d packets required 0", pkt_seen - p0); end
        n_vec++; if (dct_in_ready !== 1'b1) begin n_err++; $display("FAIL empty_flush_ready: got %b required 1", dct_in_ready); end
    endtask

    task automatic test_back_to_back();
        int acc;
        int w;
        int p0;
        logic [29:0] b0;
        acc = 0;
        dct_out_ready = 1'b0;
        dct_in_valid  = 1'b1;
        dct_in_code   = 2'b01;
        repeat (40) begin
            @(negedge clk);
            if (dct_in_ready) acc++;
            @(posedge clk);
            #1;
        end
        n_vec++; if (acc !== 30) begin n_err++; $display("FAIL bp_accepted: got %0d required 30", acc); end
        n_vec++; if (dct_in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready: got %b required 0", dct_in_ready); end
        n_vec++; if (dct_out_valid !== 1'b1 || dct_buffer !== 30'h1555_5555 || dct_count !== 4'd15) begin
            n_err++; $display("FAIL bp_held: got valid=%b buffer=%h count=%0d required 1 15555555 15", dct_out_valid, dct_buffer, dct_count);
        end
        b0 = dct_buffer;
        repeat (3) tick();
        n_vec++; if (dct_buffer !== b0 || dct_count !== 4'd15 || dct_out_valid !== 1'b1) begin
            n_err++; $display("FAIL bp_stable: got buffer=%h count=%0d required buffer=%h count=15", dct_buffer, dct_count, b0);
        end
        exp_q.push_back({30'h1555_5555, 4'd15});
        exp_q.push_back({30'h1555_5555, 4'd15});
        exp_q.push_back({30'h1, 4'd1});
        p0 = pkt_seen;
        dct_out_ready = 1'b1;
        w = 0;
        while (acc < 31 && w < 20) begin
            @(negedge clk);
            if (dct_in_ready) acc++;
            @(posedge clk);
            #1;
            w++;
        end
        dct_in_valid = 1'b0;
        n_vec++; if (acc !== 31) begin n_err++; $display("FAIL bp_31st: got %0d accepted required 31", acc); end
        flush_pulse();
        repeat (6) tick();
        n_vec++; if (pkt_seen - p0 !== 3 || exp_q.size() !== 0) begin n_err++; $display("FAIL bp_pkts: got %0d left=%0d required 3 left=0", pkt_seen - p0, exp_q.size()); end
    endtask

    task automatic test_gating();
        int p0;
        p0 = pkt_seen;
        trc_on = 1'b0;
        for (int i = 0; i < 5; i++) send_code(2'($urandom_range(0, 3)));
        flush_pulse();
        repeat (5) tick();
        n_vec++; if (pkt_seen - p0 !== 0) begin n_err++; $display("FAIL gated_pkts: got %0d required 0", pkt_seen - p0); end
        trc_on = 1'b1;
        exp_q.push_back({30'hB, 4'd2});
        send_code(2'b10);
        send_code(2'b11);
        flush_pulse();
        repeat (5) tick();
        n_vec++; if (pkt_seen - p0 !== 1 || exp_q.size() !== 0) begin n_err++; $display("FAIL gating_pkts: got %0d left=%0d required 1 left=0", pkt_seen - p0, exp_q.size()); end
    endtask

    task automatic test_reset_mid();
        int p0;
        p0 = pkt_seen;
        for (int i = 0; i < 7; i++) send_code(2'b01);
        reset = 1'b1;
        tick();
        n_vec++; if (dct_out_valid !== 1'b0 || dct_count !== 4'd0 || dct_buffer !== 30'h0 || dct_in_ready !== 1'b0) begin
            n_err++; $display("FAIL midrst_outputs: got valid=%b count=%0d buffer=%h ready=%b required all 0", dct_out_valid, dct_count, dct_buffer, dct_in_ready);
        end
        reset = 1'b0;
        tick();
        flush_pulse();
        repeat (5) tick();
        n_vec++; if (pkt_seen - p0 !== 0) begin n_err++; $display("FAIL midrst_discard: got %0d packets required 0", pkt_seen - p0); end
        dct_out_ready = 1'b0;
        for (int i = 0; i < 15; i++) send_code(2'b10);
        tick();
        n_vec++; if (dct_out_valid !== 1'b1) begin n_err++; $display("FAIL midrst_pending: got valid=%b required 1", dct_out_valid); end
        reset = 1'b1;
        tick();
        n_vec++; if (dct_out_valid !== 1'b0 || dct_count !== 4'd0 || dct_buffer !== 30'h0) begin
            n_err++; $display("FAIL outrst_outputs: got valid=%b count=%0d buffer=%h required all 0", dct_out_valid, dct_count, dct_buffer);
        end
        reset = 1'b0;
        dct_out_ready = 1'b1;
        repeat (4) tick();
        n_vec++; if (pkt_seen - p0 !== 0) begin n_err++; $display("FAIL outrst_discard: got %0d packets required 0", pkt_seen - p0); end
        exp_q.push_back({30'hD, 4'd2});
        send_code(2'b11);
        send_code(2'b01);
        flush_pulse();
        repeat (5) tick();
        n_vec++; if (pkt_seen - p0 !== 1 || exp_q.size() !== 0) begin n_err++; $display("FAIL restart_pkts: got %0d left=%0d required 1 left=0", pkt_seen - p0, exp_q.size()); end
    endtask

    task automatic test_end_of_test();
        int p0;
        dct_out_ready = 1'b0;
        send_code(2'b01);
        send_code(2'b10);
        send_code(2'b11);
        send_code(2'b00);
        send_code(2'b01);
        exp_q.push_back({30'h1B1, 4'd5});
        test_ending = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) begin
            tick();
            n_vec++; if (dct_in_ready !== 1'b0 || test_has_ended !== 1'b0) begin
                n_err++; $display("FAIL ending_hold[%0d]: got ready=%b ended=%b required 0 0", i, dct_in_ready, test_has_ended);
            end
        end
        n_vec++; if (dct_out_valid !== 1'b1 || dct_count !== 4'd5) begin n_err++; $display("FAIL ending_pkt: got valid=%b count=%0d required 1 5", dct_out_valid, dct_count); end
        p0 = pkt_seen;
        dct_out_ready = 1'b1;
        tick();
        n_vec++; if (pkt_seen - p0 !== 1 || dct_out_valid !== 1'b0 || test_has_ended !== 1'b0) begin
            n_err++; $display("FAIL ending_accept: got pkts=%0d valid=%b ended=%b required 1 0 0", pkt_seen - p0, dct_out_valid, test_has_ended);
        end
        tick();
        n_vec++; if (test_has_ended !== 1'b1) begin n_err++; $display("FAIL ended: got %b required 1", test_has_ended); end
        test_ending = 1'b0;
        repeat (5) tick();
        n_vec++; if (test_has_ended !== 1'b1 || dct_in_ready !== 1'b0) begin
            n_err++; $display("FAIL ended_sticky: got ended=%b ready=%b required 1 0", test_has_ended, dct_in_ready);
        end
        n_vec++; if (exp_q.size() !== 0) begin n_err++; $display("FAIL leftover: got %0d expected packets pending required 0", exp_q.size()); end
    endtask

    initial begin
        reset         = 1'b1;
        trc_on        = 1'b1;
        dct_in_valid  = 1'b0;
        dct_in_code   = 2'b00;
        dct_flush     = 1'b0;
        test_ending   = 1'b0;
        dct_out_ready = 1'b1;
        test_reset();
        test_full_packet();
        test_partial_flush();
        test_back_to_back();
        test_gating();
        test_reset_mid();
        test_end_of_test();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hwjsoc_cpu_oci_dct_packer.md
Name: hwjsoc_cpu_oci_dct_packer

Overview:
Transmit side of the OCI direct-conditional-branch trace (DCT) interface. It accepts 2-bit branch trace codes from the CPU trace-capture logic and packs them into the 30-bit dct_buffer / 4-bit dct_count packet. It hands each packet to the DCT consumer (trace monitor/test bench) over a valid/ready handshake. It also drives the end-of-test handshake: test_ending in, test_has_ended out.

Parameters:
CODE_W, 2, width of one trace code
DEPTH, 15, codes per full packet
BUF_W, 30, packet width; must equal CODE_W*DEPTH
CNT_W, 4, width of dct_count; must hold DEPTH

Ports:
clk  in  1  single clock, rising edge
reset  in  1  synchronous, active-high
trc_on  in  1  trace enable; accepted codes are stored only when high
dct_in_valid  in  1  trace code offered
dct_in_code  in  CODE_W  trace code
dct_in_ready  out  1  packer can accept a code
dct_flush  in  1  pulse: close the partial packet
test_ending  in  1  level: test is finishing
dct_buffer  out  BUF_W  packet payload
dct_count  out  CNT_W  number of valid codes in the packet, 1..DEPTH
dct_out_valid  out  1  packet valid
dct_out_ready  in  1  consumer accepts the packet
test_has_ended  out  1  sticky: all trace drained after test_ending

Behaviour:
- Clocking: one clock (clk). Reset is synchronous and active-high (reset).
- Reset values: dct_buffer=0, dct_count=0, dct_out_valid=0, test_has_ended=0, dct_in_ready=0 while reset is high. Accumulator, flush_pend and FSM are cleared. Reset mid-packet discards all contents; no partial packet is emitted.
- Storage: accumulator acc_buf/acc_cnt plus a one-packet output register (dct_buffer/dct_count/dct_out_valid).
- Accept: code is accepted when dct_in_valid && dct_in_ready.
  - With trc_on=1: acc_buf <= {acc_buf[BUF_W-CODE_W-1:0], code}, acc_cnt+1.
  - With trc_on=0: code is consumed and discarded.
- Packet packing: newest code sits in [1:0]; a partial packet is right-justified with its upper bits zero.
- slot_free = !dct_out_valid || dct_out_ready.
- Transfer (acc to output) on a cycle where slot_free holds and either:
  - acc_cnt==DEPTH, or
  - flush_pend && acc_cnt!=0.
  - On transfer, the output register loads acc_buf/acc_cnt, and the accumulator clears, except that a code accepted in the same cycle becomes entry 1 of the new accumulator.
- Latency: the 15th accept at edge E gives dct_out_valid=1 after edge E+1 if slot_free.
- dct_in_ready = state==RUN && !flush_pend && !(acc_cnt==DEPTH && !slot_free).
- Flush:
  - dct_flush sets flush_pend. The code accepted in the flush cycle is included.
  - flush_pend clears on transfer, or immediately if acc_cnt==0. No empty packet is ever sent.
- Output hold: while dct_out_valid && !dct_out_ready, dct_buffer and dct_count are held stable. dct_out_valid drops after acceptance unless a new transfer occurs in the same cycle (back-to-back allowed).
- acc_cnt never exceeds DEPTH and never wraps.
- FSM:
  - RUN: accepts codes. test_ending=1 moves to ENDING and sets flush_pend.
  - ENDING: dct_in_ready=0. When acc_cnt==0 && !dct_out_valid, moves to ENDED.
  - ENDED: test_has_ended=1 (registered, asserted the cycle after entry). Sticky until reset; test_ending is ignored after this point.
- Simultaneous events:
  - test_ending and dct_flush together act as a single flush.
  - test_ending with a final code on the same cycle: the code is included.

Decomposition:
- Package hwjsoc_oci_dct_pkg holds:
  - constants DCT_CODE_W=2, DCT_DEPTH=15, DCT_BUF_W=30, DCT_CNT_W=4;
  - the state enum {RUN, ENDING, ENDED}.
- Sub-module hwjsoc_oci_dct_outreg: the output holding register with its valid/ready logic.
- The accumulator and FSM stay in the top module.

Test Plan:
- Full packet: trc_on=1, out_ready=1, 15 codes alternating 01,10 starting 01 -> one packet, dct_count=15, dct_buffer=30'h1999_9999, dct_out_valid for exactly 1 cycle.
- Partial flush: codes 11,10,01 then dct_flush pulse -> dct_count=3, dct_buffer=30'h39. A following flush with the accumulator empty -> no packet.
- Backpressure: out_ready=0, offer 31 codes of 01 -> 30 accepted, dct_in_ready=0 from then on, outputs stable. Raise out_ready -> two packets, count=15, buffer=30'h1555_5555 each, then the 31st code is accepted.
- Trace gating: trc_on=0 for 5 codes, then 1 for 2 codes 10,11, then flush -> dct_count=2, dct_buffer=30'hB.
- End of test: 5 codes pending, test_ending=1, out_ready=0 for 10 cycles:
  - dct_in_ready=0 and test_has_ended=0 throughout;
  - raise out_ready -> packet count=5 accepted, test_has_ended=1 the next cycle and stays 1.
- Reset mid-operation: reset after 7 codes and again with a pending output -> all outputs 0, no packet emitted; post-reset operation restarts with count from 0.
